// File: rtl/rf_frontend_sequencer.sv
// rf_frontend_sequencer: RF front-end sequencing (detector warm-up, tone/FSK switch drive, shutdown); RF_SW_DEADTIME_EN adds break-before-make
module rf_frontend_sequencer #(
   parameter int NUM_SW     = 2,
   parameter int DIV_W      = 8,
   parameter int BIT_W      = 10,
   parameter int WARMUP_CYC = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        mode,
   input  logic [DIV_W-1:0]  half_period0,
   input  logic [DIV_W-1:0]  half_period1,
   input  logic [BIT_W-1:0]  bit_len,
   input  logic              data_bit,
   input  logic              data_valid,
   output logic              data_ready,
   output logic [NUM_SW-1:0] switch_control,
   output logic              envelop_detector_enable,
   output logic              listening,
   output logic              busy,
   output logic              underrun
);
   localparam int PW = $clog2(NUM_SW);
   localparam int WW = $clog2(WARMUP_CYC + 1);
   localparam logic [PW-1:0] LAST = PW'(NUM_SW - 1);
   localparam logic [NUM_SW-1:0] ONE = NUM_SW'(1);
   typedef enum logic [2:0] {IDLE, WARMUP, LISTEN, TONE, DATA} state_t;
   state_t state;
   logic [PW-1:0] phase, phase_nx;
   logic [DIV_W-1:0] step_cnt, hp0_q, hp1_q, hp_cur;
   logic [BIT_W-1:0] bit_cnt, bl_m1;
   logic [WW-1:0] warm_cnt;
   logic bit_q, bit_end, step;
`ifdef RF_SW_DEADTIME_EN
   logic dead;
`endif

   // active step interval, next phase and bit-boundary decode
   always_comb begin
      hp_cur = (state == DATA && bit_q) ? hp1_q : hp0_q;
      phase_nx = (phase == LAST) ? '0 : phase + 1'b1;
      bit_end = bit_cnt >= bl_m1;
`ifdef RF_SW_DEADTIME_EN
      step = (step_cnt >= hp_cur) && !dead;
`else
      step = step_cnt >= hp_cur;
`endif
   end

   // sequencer FSM with registered drive outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         phase <= '0;
         step_cnt <= '0;
         hp0_q <= '0;
         hp1_q <= '0;
         bit_cnt <= '0;
         bl_m1 <= '0;
         warm_cnt <= '0;
         bit_q <= 1'b0;
`ifdef RF_SW_DEADTIME_EN
         dead <= 1'b0;
`endif
         data_ready <= 1'b0;
         switch_control <= '0;
         envelop_detector_enable <= 1'b0;
         listening <= 1'b0;
         busy <= 1'b0;
         underrun <= 1'b0;
      end else begin
         data_ready <= 1'b0;
         if (stop) begin
            state <= IDLE;
            switch_control <= '0;
            envelop_detector_enable <= 1'b0;
            listening <= 1'b0;
            busy <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  underrun <= 1'b0;
                  phase <= '0;
                  step_cnt <= '0;
                  bit_cnt <= '0;
                  warm_cnt <= '0;
                  hp0_q <= half_period0;
                  hp1_q <= half_period1;
                  bl_m1 <= (bit_len == '0) ? '0 : bit_len - 1'b1;
                  bit_q <= data_bit;
`ifdef RF_SW_DEADTIME_EN
                  dead <= 1'b0;
`endif
                  case (mode)
                     2'b01: begin
                        state <= WARMUP;
                        envelop_detector_enable <= 1'b1;
                        busy <= 1'b1;
                     end
                     2'b10: begin
                        state <= TONE;
                        switch_control <= ONE;
                        busy <= 1'b1;
                     end
                     2'b11: if (data_valid) begin
                        state <= DATA;
                        switch_control <= ONE;
                        busy <= 1'b1;
                        data_ready <= 1'b1;
                     end else underrun <= 1'b1;
                     default: ;
                  endcase
               end
               WARMUP: if (warm_cnt == WW'(WARMUP_CYC - 1)) begin
                  state <= LISTEN;
                  listening <= 1'b1;
               end else warm_cnt <= warm_cnt + 1'b1;
               LISTEN: ;
               TONE, DATA: if (state == DATA && bit_end && !data_valid) begin
                  state <= IDLE;
                  switch_control <= '0;
                  busy <= 1'b0;
                  underrun <= 1'b1;
               end else begin
                  if (state == DATA) begin
                     bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
                     if (bit_end) begin
                        bit_q <= data_bit;
                        data_ready <= 1'b1;
                     end
                  end
                  if (step) phase <= phase_nx;
`ifdef RF_SW_DEADTIME_EN
                  dead <= step;
                  step_cnt <= (step_cnt >= hp_cur) ? '0 : step_cnt + 1'b1;
                  switch_control <= step ? '0 : ONE << phase;
`else
                  step_cnt <= step ? '0 : step_cnt + 1'b1;
                  switch_control <= ONE << (step ? phase_nx : phase);
`endif
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_rf_frontend_sequencer.sv
// tb_rf_frontend_sequencer: directed and randomized checks against a behavioural model
module tb_rf_frontend_sequencer;
   localparam int NUM_SW = 2;
   localparam int WARMUP_CYC = 16;
`ifdef RF_SW_DEADTIME_EN
   localparam bit DT = 1'b1;
`else
   localparam bit DT = 1'b0;
`endif
   logic clock = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
   logic [1:0] mode = '0;
   logic [7:0] half_period0 = '0, half_period1 = '0;
   logic [9:0] bit_len = '0;
   logic data_bit = 1'b0, data_valid = 1'b0;
   logic data_ready, envelop_detector_enable, listening, busy, underrun;
   logic [NUM_SW-1:0] switch_control;
   int n_checks = 0, n_fail = 0;
   bit chk_en = 1'b0;

   rf_frontend_sequencer #(.NUM_SW(NUM_SW), .DIV_W(8), .BIT_W(10), .WARMUP_CYC(WARMUP_CYC)) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
      .half_period0(half_period0), .half_period1(half_period1), .bit_len(bit_len),
      .data_bit(data_bit), .data_valid(data_valid), .data_ready(data_ready),
      .switch_control(switch_control), .envelop_detector_enable(envelop_detector_enable),
      .listening(listening), .busy(busy), .underrun(underrun)
   );

   always #5 clock = ~clock;

   // model: st 0 idle, 1 warm-up, 2 listen, 3 tone, 4 data
   int m_st, m_ph, m_pos, m_bpos, m_bit, m_hp0, m_hp1, m_bl, m_warm, m_hp;
   bit m_dz, m_dr, m_ur;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_st = 0; m_ph = 0; m_pos = 0; m_bpos = 0; m_bit = 0; m_warm = 0;
         m_dz = 0; m_dr = 0; m_ur = 0;
      end else begin
         m_dr = 0;
         if (stop) m_st = 0;
         else if (m_st == 0) begin
            if (start) begin
               m_ur = 0; m_ph = 0; m_pos = 0; m_bpos = 0; m_dz = 0; m_warm = 0;
               m_hp0 = half_period0; m_hp1 = half_period1;
               m_bl = (bit_len == 0) ? 1 : int'(bit_len);
               if (mode == 2'b01) m_st = 1;
               else if (mode == 2'b10) m_st = 3;
               else if (mode == 2'b11) begin
                  if (data_valid) begin m_st = 4; m_bit = data_bit; m_dr = 1; end
                  else m_ur = 1;
               end
            end
         end else if (m_st == 1) begin
            m_warm++;
            if (m_warm == WARMUP_CYC) m_st = 2;
         end else if (m_st >= 3) begin
            m_hp = (m_st == 4 && m_bit != 0) ? m_hp1 : m_hp0;
            if (m_st == 4 && m_bpos == m_bl - 1 && !data_valid) begin
               m_st = 0; m_ur = 1;
            end else begin
               if (m_st == 4) begin
                  if (m_bpos == m_bl - 1) begin m_bpos = 0; m_bit = data_bit; m_dr = 1; end
                  else m_bpos++;
               end
               if (!m_dz && m_pos >= m_hp) begin
                  m_ph = (m_ph + 1) % NUM_SW; m_pos = 0; m_dz = DT;
               end else begin
                  m_pos = (m_pos >= m_hp) ? 0 : m_pos + 1; m_dz = 0;
               end
            end
         end
      end
   end

   function automatic logic [NUM_SW+4:0] model_out();
      logic [NUM_SW-1:0] sw;
      sw = (m_st >= 3 && !m_dz) ? NUM_SW'(1 << m_ph) : '0;
      return {sw, m_st == 1 || m_st == 2, m_st == 2, m_st != 0, m_dr, m_ur};
   endfunction

   // every cycle: DUT outputs against the model
   always @(negedge clock) begin
      if (chk_en) begin
         logic [NUM_SW+4:0] got, exp;
         got = {switch_control, envelop_detector_enable, listening, busy, data_ready, underrun};
         exp = model_out();
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
               $display("FAIL model_cmp t=%0t got {sw,env,lis,busy,rdy,urun}=%b required %b", $time, got, exp);
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got %0d required %0d", name, $time, got, exp);
      end
   endtask

   task automatic pulse_start(input logic [1:0] m);
      mode = m; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
   endtask

   logic [1:0] exp_tone [16];
   logic [1:0] exp_data [16];
   int n, dr_first, dr_last, dr_cnt;

   initial begin
      if (DT) begin
         exp_tone = '{1,1,1,1,0,2,2,2,0,1,1,1,0,2,2,2};
         exp_data = '{1,1,0,2,0,1,0,2,0,1,1,1,0,2,2,2};
      end else begin
         exp_tone = '{1,1,1,1,2,2,2,2,1,1,1,1,2,2,2,2};
         exp_data = '{1,1,2,2,1,1,2,2,1,1,1,1,2,2,2,2};
      end
      #2 reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset_sw", int'(switch_control), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_env", int'(envelop_detector_enable), 0);
      reset = 1'b1;
      chk_en = 1'b1;
      @(negedge clock);
      // warm-up and listen
      pulse_start(2'b01);
      chk("warm_env", int'(envelop_detector_enable), 1);
      n = 0;
      while (!listening && n < 100) begin @(negedge clock); n++; end
      chk("warm_len", n, 16);
      chk("listen_sw", int'(switch_control), 0);
      pulse_stop();
      chk("stop_env", int'(envelop_detector_enable), 0);
      chk("stop_busy", int'(busy), 0);
      // tone, half period 3
      half_period0 = 8'd3;
      pulse_start(2'b10);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("tone_sw%0d", i), int'(switch_control), int'(exp_tone[i]));
         @(negedge clock);
      end
      // async reset mid-tone
      @(posedge clock);
      #3 reset = 1'b0;
      #1;
      chk("areset_sw", int'(switch_control), 0);
      chk("areset_busy", int'(busy), 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      // FSK data: bits 0 then 1
      half_period0 = 8'd1; half_period1 = 8'd3; bit_len = 10'd8;
      data_bit = 1'b0; data_valid = 1'b1;
      pulse_start(2'b11);
      dr_cnt = 0; dr_first = -1; dr_last = -1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("data_sw%0d", i), int'(switch_control), int'(exp_data[i]));
         if (data_ready) begin
            dr_cnt++;
            if (dr_first < 0) dr_first = i;
            dr_last = i;
            data_bit = 1'b1;
         end
         @(negedge clock);
      end
      chk("data_rdy_cnt", dr_cnt, 2);
      chk("data_rdy_first", dr_first, 0);
      chk("data_rdy_gap", dr_last - dr_first, 8);
      pulse_stop();
      // underrun at second boundary
      bit_len = 10'd4; data_valid = 1'b1;
      pulse_start(2'b11);
      repeat (4) @(negedge clock);
      data_valid = 1'b0;
      repeat (4) @(negedge clock);
      chk("urun_flag", int'(underrun), 1);
      chk("urun_busy", int'(busy), 0);
      chk("urun_sw", int'(switch_control), 0);
      data_valid = 1'b1;
      pulse_start(2'b10);
      chk("urun_clear", int'(underrun), 0);
      chk("restart_busy", int'(busy), 1);
      pulse_stop();
      // start and stop together in IDLE
      start = 1'b1; stop = 1'b1; mode = 2'b10;
      @(negedge clock);
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", int'(busy), 0);
      chk("startstop_sw", int'(switch_control), 0);
      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 9) == 0);
         stop = ($urandom_range(0, 39) == 0);
         mode = 2'($urandom);
         half_period0 = 8'($urandom_range(0, 4));
         half_period1 = 8'($urandom_range(0, 4));
         bit_len = 10'($urandom_range(0, 5));
         data_bit = 1'($urandom);
         data_valid = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 599) == 0) begin
            @(posedge clock);
            #3 reset = 1'b0;
            #1 chk("rand_areset_busy", int'(busy), 0);
            @(negedge clock);
            reset = 1'b1;
         end else @(negedge clock);
      end
      start = 1'b0; stop = 1'b0;
      repeat (2) @(negedge clock);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
